fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter addressSize, default 64, width of the instruction address.
REQ-002 SHALL have parameter instructionSize, default 32, width of one instruction word.
REQ-003 SHALL have parameter queueDepth, default 4, number of entries (a power of two, at least 2).
REQ-004 SHALL have port clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port flushPipeline_i, input, 1 bit: discard all queued and output entries.
REQ-007 SHALL have port enable_i, input, 1 bit: fetch unit presents a valid instruction this cycle.
REQ-008 SHALL have port instruction_i, input, instructionSize bits: the fetched instruction word.
REQ-009 SHALL have port instructionAddress_i, input, addressSize bits: the fetched instruction's address.
REQ-010 SHALL have port stall_i, input, 1 bit: decode cannot accept; output registers hold.
REQ-011 SHALL have port enable_o, input-to-decode valid, output, 1 bit: the output registers hold a valid entry.
REQ-012 SHALL have port instruction_o, output, instructionSize bits: the instruction presented to decode.
REQ-013 SHALL have port instructionAddress_o, output, addressSize bits: the address presented to decode.
REQ-014 SHALL have port full_o, output, 1 bit: combinational, high when count equals queueDepth; fetch gates its enable on it.
REQ-015 SHALL have port count_o, output, clog2(queueDepth)+1 bits: number of occupied storage entries (excluding the output register).
REQ-016 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a push is dropped.

Function
REQ-017 SHALL hold the storage as a circular buffer with head/tail pointers of clog2(queueDepth) bits that wrap from queueDepth-1 to 0.
REQ-018 SHALL pop, when stall_i is low, the head entry into the output registers and set enable_o high; with stall_i low and count 0, enable_o SHALL go low.
REQ-019 SHALL hold enable_o, instruction_o and instructionAddress_o unchanged while stall_i is high.
REQ-020 SHALL accept a push when enable_i is high and either count < queueDepth or a pop occurs in the same cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL drop a push attempted when full with no pop, leave the storage unchanged, and set overflow_o.
REQ-022 SHALL give a latency of 2 cycles from push to enable_o high on an empty, unstalled queue (the entry is written at edge N and reaches the outputs at edge N+1).
REQ-023 SHALL give flushPipeline_i priority over push, pop and stall: at the next edge count, pointers, enable_o and overflow_o go to 0, and a push in the flush cycle is discarded.
REQ-024 SHALL leave instruction_o and instructionAddress_o don't-care whenever enable_o is 0.

Reset
REQ-025 SHALL, when reset_i is low at a rising edge, clear enable_o, instruction_o, instructionAddress_o, count_o, overflow_o and the pointers to 0; reset overrides flushPipeline_i and any in-flight push or pop.
REQ-026 SHALL leave the storage contents undefined after reset; only the pointers and count define occupancy.

Configuration
REQ-027 SHALL support macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count is 0, the output register will be empty or popping next edge, stall_i is low, and enable_i is high, the input loads directly into the output registers at that edge. This gives a latency of 1, and count stays 0.
- Undefined: behaviour is exactly REQ-022 with no bypass path.

Structure
REQ-028 SHALL take from a shared core package:
- the queue entry typedef {address, instruction};
- the default queueDepth constant;
- the addressSize and instructionSize constants.
REQ-029 SHALL place the storage array in one sub-module, fetch_queue_ram, with one write port and one asynchronous read port; pointer, count and output logic stay in fetch_queue.

Verification
REQ-030 SHALL cover reset: reset_i low for 2 cycles mid-stream with 3 entries queued -> count_o=0, enable_o=0, overflow_o=0 on the next edge.
REQ-031 SHALL cover basic flow: push address 0x1000/instruction 0x38600001 on an empty queue with stall_i low -> enable_o high with those values 2 cycles later (1 cycle with FETCH_QUEUE_BYPASS_EN).
REQ-032 SHALL cover fill and overflow: stall_i high, push 5 entries 0x1000..0x1010 -> full_o after the 4th push, 5th dropped, overflow_o=1; release stall -> outputs 0x1000, 0x1004, 0x1008, 0x100C in order.
REQ-033 SHALL cover wrap-around: 10 consecutive push/pop cycles at depth 4 -> addresses emerge in order with no loss, count_o constant.
REQ-034 SHALL cover flush: flushPipeline_i with 3 queued entries and a simultaneous push -> next edge enable_o=0 and count_o=0; the following push of 0x2000 is the next output.
REQ-035 SHALL cover push while full: full with stall_i low and enable_i high -> push accepted, count_o stays 4, overflow_o stays 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for the fetch queue: entry layout, default widths and depth.
package fetch_queue_pkg;

    localparam int ADDRESS_SIZE     = 64;
    localparam int INSTRUCTION_SIZE = 32;
    localparam int QUEUE_DEPTH      = 4;

    // One queued fetch: the address sits above the instruction word when packed.
    typedef struct packed {
        logic [ADDRESS_SIZE-1:0]     address;
        logic [INSTRUCTION_SIZE-1:0] instruction;
    } fetch_entry_t;

    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus of the fetch queue: fetch-side push, decode-side stall/output, status.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int addressSize     = ADDRESS_SIZE,
    parameter int instructionSize = INSTRUCTION_SIZE,
    parameter int queueDepth      = QUEUE_DEPTH
);

    logic                          flushPipeline_i;
    logic                          enable_i;
    logic [instructionSize-1:0]    instruction_i;
    logic [addressSize-1:0]        instructionAddress_i;
    logic                          stall_i;
    logic                          enable_o;
    logic [instructionSize-1:0]    instruction_o;
    logic [addressSize-1:0]        instructionAddress_o;
    logic                          full_o;
    logic [$clog2(queueDepth):0]   count_o;
    logic                          overflow_o;

    // The pipeline side drives fetch, flush and stall, and observes the queue outputs.
    modport master (
        output flushPipeline_i, enable_i, instruction_i, instructionAddress_i, stall_i,
        input  enable_o, instruction_o, instructionAddress_o, full_o, count_o, overflow_o
    );

    // The queue itself consumes the pipeline inputs and drives the outputs.
    modport slave (
        input  flushPipeline_i, enable_i, instruction_i, instructionAddress_i, stall_i,
        output enable_o, instruction_o, instructionAddress_o, full_o, count_o, overflow_o
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// Storage array of the fetch queue: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy is tracked entirely by the pointers in fetch_queue.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int depth = QUEUE_DEPTH,
    parameter int width = ENTRY_WIDTH
) (
    input  logic                     clock_i,
    input  logic                     write_en_i,
    input  logic [$clog2(depth)-1:0] write_addr_i,
    input  logic [width-1:0]         write_data_i,
    input  logic [$clog2(depth)-1:0] read_addr_i,
    output logic [width-1:0]         read_data_o
);

    logic [width-1:0] mem_q [depth];

    // Write the tail entry on the rising edge when a push is accepted.
    always_ff @(posedge clock_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
    end

    assign read_data_o = mem_q[read_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between fetch and decode: circular buffer plus one output register stage.
// Optional macro FETCH_QUEUE_BYPASS_EN lets a push into an empty, unstalled queue
// load straight into the output register (latency 1 instead of 2).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int addressSize     = ADDRESS_SIZE,
    parameter int instructionSize = INSTRUCTION_SIZE,
    parameter int queueDepth      = QUEUE_DEPTH
) (
    input  logic         clock_i,
    input  logic         reset_i,
    fetch_queue_if.slave bus
);

    localparam int PTR_W   = $clog2(queueDepth);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = addressSize + instructionSize;

    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       out_valid_q, out_valid_d;
    logic [addressSize-1:0]     out_addr_q, out_addr_d;
    logic [instructionSize-1:0] out_inst_q, out_inst_d;
    logic                       overflow_q, overflow_d;

    logic                       full;
    logic                       pop;
    logic                       push;
    logic                       drop;
    logic                       bypass;
    logic                       write_en;
    logic [ENTRY_W-1:0]         write_data;
    logic [ENTRY_W-1:0]         read_data;

    fetch_queue_ram #(
        .depth (queueDepth),
        .width (ENTRY_W)
    ) u_ram (
        .clock_i      (clock_i),
        .write_en_i   (write_en),
        .write_addr_i (tail_q),
        .write_data_i (write_data),
        .read_addr_i  (head_q),
        .read_data_o  (read_data)
    );

    // Decide this cycle's pop, push, drop and (optionally) bypass from count and handshakes.
    always_comb begin
        full   = (count_q == CNT_W'(queueDepth));
        pop    = !bus.stall_i && (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = !bus.stall_i && bus.enable_i && (count_q == '0);
`else
        bypass = 1'b0;
`endif
        push       = bus.enable_i && !bypass && (!full || pop);
        drop       = bus.enable_i && full && !pop;
        write_en   = push && !bus.flushPipeline_i;
        write_data = {bus.instructionAddress_i, bus.instruction_i};
    end

    // Next-state for pointers, count, output register and sticky overflow; flush wins over all.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_inst_d  = out_inst_q;
        overflow_d  = overflow_q;
        if (bus.flushPipeline_i) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (!bus.stall_i) begin
                if (pop) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = read_data[ENTRY_W-1:instructionSize];
                    out_inst_d  = read_data[instructionSize-1:0];
                end else if (bypass) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = bus.instructionAddress_i;
                    out_inst_d  = bus.instruction_i;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    // Register all control state; synchronous active-low reset overrides flush and traffic.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_inst_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_inst_q  <= out_inst_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.enable_o             = out_valid_q;
    assign bus.instructionAddress_o = out_addr_q;
    assign bus.instruction_o        = out_inst_q;
    assign bus.count_o              = count_q;
    assign bus.full_o               = full;
    assign bus.overflow_o           = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
    } model_entry_t;

    logic clock;
    logic reset_n;

    int compare_count  = 0;
    int mismatch_count = 0;

    model_entry_t model_q[$];
    logic         model_valid;
    logic [63:0]  model_addr;
    logic [31:0]  model_inst;
    logic         model_ovf;

    fetch_queue_if #(.addressSize(64), .instructionSize(32), .queueDepth(DEPTH)) bus ();

    fetch_queue #(
        .addressSize     (64),
        .instructionSize (32),
        .queueDepth      (DEPTH)
    ) dut (
        .clock_i (clock),
        .reset_i (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour for one rising edge, given the inputs held during the cycle.
    task automatic modelStep(input bit rst_n, input bit flush, input bit en, input bit stall,
                             input logic [63:0] addr, input logic [31:0] inst);
        bit was_full;
        bit popping;
        bit bypassing;
        model_entry_t e;
        if (!rst_n) begin
            model_q.delete();
            model_valid = 1'b0;
            model_addr  = '0;
            model_inst  = '0;
            model_ovf   = 1'b0;
        end else if (flush) begin
            model_q.delete();
            model_valid = 1'b0;
            model_ovf   = 1'b0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            popping   = !stall && (model_q.size() > 0);
            bypassing = BYPASS && !stall && en && (model_q.size() == 0);
            if (!stall) begin
                if (popping) begin
                    e = model_q.pop_front();
                    model_valid = 1'b1;
                    model_addr  = e.addr;
                    model_inst  = e.inst;
                end else if (bypassing) begin
                    model_valid = 1'b1;
                    model_addr  = addr;
                    model_inst  = inst;
                end else begin
                    model_valid = 1'b0;
                end
            end
            if (en && !bypassing) begin
                if (!was_full || popping) begin
                    e.addr = addr;
                    e.inst = inst;
                    model_q.push_back(e);
                end else begin
                    model_ovf = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, then compare all outputs.
    task automatic applyStimulus(input bit rst_n, input bit flush, input bit en, input bit stall,
                                 input logic [63:0] addr, input logic [31:0] inst);
        reset_n                  = rst_n;
        bus.flushPipeline_i      = flush;
        bus.enable_i             = en;
        bus.stall_i              = stall;
        bus.instructionAddress_i = addr;
        bus.instruction_i        = inst;
        @(posedge clock);
        modelStep(rst_n, flush, en, stall, addr, inst);
        #1;
        checkOutput("enable", 64'(bus.enable_o), 64'(model_valid));
        checkOutput("count", 64'(bus.count_o), 64'(model_q.size()));
        checkOutput("full", 64'(bus.full_o), 64'(model_q.size() == DEPTH));
        checkOutput("overflow", 64'(bus.overflow_o), 64'(model_ovf));
        if (model_valid) begin
            checkOutput("address", bus.instructionAddress_o, model_addr);
            checkOutput("instruction", 64'(bus.instruction_o), 64'(model_inst));
        end
        @(negedge clock);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input bit stall);
        applyStimulus(1'b1, 1'b0, 1'b0, stall, '0, '0);
    endtask

    task automatic pushEntry(input logic [63:0] addr, input bit stall);
        applyStimulus(1'b1, 1'b0, 1'b1, stall, addr, 32'hC0DE_0000 | 32'(addr[15:0]));
    endtask

    initial begin
        reset_n                  = 1'b0;
        bus.flushPipeline_i      = 1'b0;
        bus.enable_i             = 1'b0;
        bus.stall_i              = 1'b0;
        bus.instructionAddress_i = '0;
        bus.instruction_i        = '0;
        @(negedge clock);

        // Reset state.
        doReset();
        checkOutput("rst_enable", 64'(bus.enable_o), 64'd0);
        checkOutput("rst_count", 64'(bus.count_o), 64'd0);

        // Basic flow with the canonical first instruction.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 32'h3860_0001);
        if (!BYPASS) begin
            checkOutput("flow_early", 64'(bus.enable_o), 64'd0);
            idle(1'b0);
        end
        checkOutput("flow_enable", 64'(bus.enable_o), 64'd1);
        checkOutput("flow_addr", bus.instructionAddress_o, 64'h1000);
        checkOutput("flow_inst", 64'(bus.instruction_o), 64'h3860_0001);

        // Fill while stalled, then overflow and drain in order.
        doReset();
        for (int i = 0; i < 5; i++) begin
            pushEntry(64'h1000 + 64'(4 * i), 1'b1);
            if (i == 3) checkOutput("fill_full", 64'(bus.full_o), 64'd1);
        end
        checkOutput("fill_ovf", 64'(bus.overflow_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            checkOutput("drain_addr", bus.instructionAddress_o, 64'h1000 + 64'(4 * i));
        end
        checkOutput("drain_count", 64'(bus.count_o), 64'd0);
        idle(1'b0);
        checkOutput("drain_empty", 64'(bus.enable_o), 64'd0);

        // Wrap-around: steady push/pop keeps occupancy constant.
        doReset();
        pushEntry(64'h3000, 1'b1);
        pushEntry(64'h3004, 1'b1);
        for (int i = 0; i < 10; i++) begin
            pushEntry(64'h3008 + 64'(4 * i), 1'b0);
            checkOutput("wrap_count", 64'(bus.count_o), 64'd2);
            checkOutput("wrap_addr", bus.instructionAddress_o, 64'h3000 + 64'(4 * i));
        end

        // Flush with a simultaneous push, then the next push is the next output.
        doReset();
        for (int i = 0; i < 3; i++) pushEntry(64'h1000 + 64'(4 * i), 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h1FFC, 32'h1);
        checkOutput("flush_enable", 64'(bus.enable_o), 64'd0);
        checkOutput("flush_count", 64'(bus.count_o), 64'd0);
        pushEntry(64'h2000, 1'b0);
        if (!BYPASS) idle(1'b0);
        checkOutput("flush_next", bus.instructionAddress_o, 64'h2000);

        // Push while full with decode ready is accepted.
        doReset();
        for (int i = 0; i < 4; i++) pushEntry(64'h4000 + 64'(4 * i), 1'b1);
        pushEntry(64'h4010, 1'b0);
        checkOutput("pf_count", 64'(bus.count_o), 64'd4);
        checkOutput("pf_ovf", 64'(bus.overflow_o), 64'd0);

        // Reset mid-stream with three entries queued.
        doReset();
        for (int i = 0; i < 3; i++) pushEntry(64'h5000 + 64'(4 * i), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h5FFC, 32'h2);
        checkOutput("midrst_count", 64'(bus.count_o), 64'd0);
        checkOutput("midrst_enable", 64'(bus.enable_o), 64'd0);
        checkOutput("midrst_ovf", 64'(bus.overflow_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 4),
                          {32'($urandom), 32'($urandom)},
                          32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
